// File: rtl/arm_cond_pkg.sv
// Shared definitions for the ARM flag/condition logic: ALU opcodes, condition codes,
// NZCV bit positions and the opcode-to-flag-update classification.
package arm_cond_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_ADC   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SBC   = 4'b0011;
    localparam logic [3:0] OP_RSB   = 4'b0100;
    localparam logic [3:0] OP_RSC   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_ORR   = 4'b0111;
    localparam logic [3:0] OP_EOR   = 4'b1000;
    localparam logic [3:0] OP_PASSA = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;
    localparam logic [3:0] OP_MVN   = 4'b1011;
    localparam logic [3:0] OP_BIC   = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        UpdNone,
        UpdAdd,
        UpdSub,
        UpdLogic
    } upd_kind_e;

    function automatic upd_kind_e upd_kind(input logic [3:0] op);
        upd_kind_e kind;
        kind = UpdNone;
        if (op <= OP_ADC) begin
            kind = UpdAdd;
        end else if (op <= OP_RSC) begin
            kind = UpdSub;
        end else if (op <= OP_BIC) begin
            kind = UpdLogic;
        end
        return kind;
    endfunction

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-field evaluator: (cond, {N,Z,C,V}) -> pass.
// Kept standalone so the branch unit can reuse it.
module arm_cond_eval
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_flag_cond_unit.sv
// NZCV flag register with ALU/direct-write update, ALU carry-in, and a registered
// condition check that sees same-cycle flag updates.
module arm_flag_cond_unit
    import arm_cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RST  = 4'b0000,
    parameter bit         INV_SUB_C = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd_valid,
    input  logic       s_bit,
    input  logic [3:0] alu_op,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       shifter_c,
    input  logic       flag_wr,
    input  logic [3:0] flag_wdata,
    input  logic       cond_valid,
    input  logic [3:0] cond,
    output logic       cin,
    output logic [3:0] flags_q,
    output logic       cond_out_valid,
    output logic       cond_pass
);

    logic [3:0] flags_d;
    logic       eval_pass;
    logic       sub_c;

    // ARM carry after subtract is NOT borrow when the ALU reports borrow.
    assign sub_c = INV_SUB_C ? ~alu_c : alu_c;

    always_comb begin
        flags_d = flags_q;
        if (flag_wr) begin
            flags_d = flag_wdata;
        end else if (upd_valid && s_bit) begin
            unique case (upd_kind(alu_op))
                UpdAdd:   flags_d = {alu_n, alu_z, alu_c, alu_v};
                UpdSub:   flags_d = {alu_n, alu_z, sub_c, alu_v};
                UpdLogic: flags_d = {alu_n, alu_z, shifter_c, flags_q[FLAG_V]};
                UpdNone:  flags_d = flags_q;
                default:  flags_d = flags_q;
            endcase
        end
    end

    // Evaluate on the next-state flags so a same-cycle update is forwarded.
    arm_cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (flags_d),
        .pass (eval_pass)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q        <= FLAG_RST;
            cond_out_valid <= 1'b0;
            cond_pass      <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            cond_out_valid <= cond_valid;
            if (cond_valid) begin
                cond_pass <= eval_pass;
            end
        end
    end

    assign cin = flags_q[FLAG_C];

endmodule

// File: tb/tb_arm_flag_cond_unit.sv
// Directed bench for arm_flag_cond_unit: hand-computed vector table, ALU update sequences,
// and a full cond x NZCV sweep against an independently structured reference.
module tb_arm_flag_cond_unit;
    import arm_cond_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       upd_valid;
    logic       s_bit;
    logic [3:0] alu_op;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       shifter_c;
    logic       flag_wr;
    logic [3:0] flag_wdata;
    logic       cond_valid;
    logic [3:0] cond;
    logic       cin;
    logic [3:0] flags_q;
    logic       cond_out_valid;
    logic       cond_pass;

    int checks = 0;
    int errors = 0;

    arm_flag_cond_unit #(
        .FLAG_RST  (4'b0000),
        .INV_SUB_C (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .upd_valid      (upd_valid),
        .s_bit          (s_bit),
        .alu_op         (alu_op),
        .alu_n          (alu_n),
        .alu_z          (alu_z),
        .alu_c          (alu_c),
        .alu_v          (alu_v),
        .shifter_c      (shifter_c),
        .flag_wr        (flag_wr),
        .flag_wdata     (flag_wdata),
        .cond_valid     (cond_valid),
        .cond           (cond),
        .cin            (cin),
        .flags_q        (flags_q),
        .cond_out_valid (cond_out_valid),
        .cond_pass      (cond_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] wdata;
        logic [3:0] cnd;
        logic       exp;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_valid  = 1'b0;
        s_bit      = 1'b0;
        alu_op     = 4'b0000;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        shifter_c  = 1'b0;
        flag_wr    = 1'b0;
        flag_wdata = 4'b0000;
        cond_valid = 1'b0;
        cond       = 4'h0;
    endtask

    task automatic alu_upd(input logic [3:0] op, input logic s, input logic [3:0] nzcv,
                           input logic sc);
        idle();
        upd_valid = 1'b1;
        s_bit     = s;
        alu_op    = op;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        shifter_c = sc;
    endtask

    task automatic query(input string name, input logic [3:0] c, input logic exp);
        idle();
        cond_valid = 1'b1;
        cond       = c;
        tick();
        check({name, " valid"}, {3'b0, cond_out_valid}, 4'd1);
        check(name, {3'b0, cond_pass}, {3'b0, exp});
    endtask

    // Reference: even/odd condition pairs are complements; pair 7 is AL/NV.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n ~^ v);
            3'd6: base = !z && (n ~^ v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    initial begin
        logic last_exp;
        vecs[0]  = '{4'b0000, COND_EQ, 1'b0};
        vecs[1]  = '{4'b0100, COND_EQ, 1'b1};
        vecs[2]  = '{4'b0100, COND_NE, 1'b0};
        vecs[3]  = '{4'b0010, COND_CS, 1'b1};
        vecs[4]  = '{4'b0000, COND_CC, 1'b1};
        vecs[5]  = '{4'b1000, COND_MI, 1'b1};
        vecs[6]  = '{4'b0111, COND_PL, 1'b1};
        vecs[7]  = '{4'b0001, COND_VS, 1'b1};
        vecs[8]  = '{4'b0001, COND_VC, 1'b0};
        vecs[9]  = '{4'b0010, COND_HI, 1'b1};
        vecs[10] = '{4'b0110, COND_HI, 1'b0};
        vecs[11] = '{4'b0110, COND_LS, 1'b1};
        vecs[12] = '{4'b1001, COND_GE, 1'b1};
        vecs[13] = '{4'b1000, COND_LT, 1'b1};
        vecs[14] = '{4'b1001, COND_GT, 1'b1};
        vecs[15] = '{4'b1101, COND_GT, 1'b0};
        vecs[16] = '{4'b0000, COND_LE, 1'b0};
        vecs[17] = '{4'b1000, COND_LE, 1'b1};
        vecs[18] = '{4'b0000, COND_AL, 1'b1};
        vecs[19] = '{4'b1111, COND_NV, 1'b0};

        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst flags", flags_q, 4'b0000);
        check("rst cin", {3'b0, cin}, 4'd0);
        check("rst valid", {3'b0, cond_out_valid}, 4'd0);
        check("rst pass", {3'b0, cond_pass}, 4'd0);
        rst_n = 1'b1;

        // Add with carry out: 0x9C000038 + 0x70000003 = 0x0C00003B, c=1 v=0.
        alu_upd(OP_ADD, 1'b1, 4'b0010, 1'b0);
        tick();
        check("add flags", flags_q, 4'b0010);
        check("add cin", {3'b0, cin}, 4'd1);
        check("add novalid", {3'b0, cond_out_valid}, 4'd0);
        query("add CS", COND_CS, 1'b1);

        // Subtract: 0x2C000035, borrow c=0, v=1 -> ARM C=1.
        alu_upd(OP_SUB, 1'b1, 4'b0001, 1'b0);
        tick();
        check("sub flags", flags_q, 4'b0011);
        query("sub VS", COND_VS, 1'b1);
        query("sub CS", COND_CS, 1'b1);
        query("sub GE", COND_GE, 1'b0);
        query("sub LT", COND_LT, 1'b1);

        // Logical: C from shifter, V retained.
        alu_upd(OP_AND, 1'b1, 4'b0110, 1'b0);
        tick();
        check("logic flags", flags_q, 4'b0101);
        alu_upd(OP_ADD, 1'b0, 4'b1111, 1'b1);
        tick();
        check("s0 hold", flags_q, 4'b0101);
        alu_upd(4'b1101, 1'b1, 4'b1010, 1'b1);
        tick();
        check("op1101 hold", flags_q, 4'b0101);
        alu_upd(OP_RSC, 1'b1, 4'b1010, 1'b0);
        tick();
        check("rsc flags", flags_q, 4'b1000);
        alu_upd(OP_BIC, 1'b1, 4'b0000, 1'b1);
        tick();
        check("bic flags", flags_q, 4'b0010);

        // Direct write wins over a same-cycle ALU add; same-cycle MI sees it.
        alu_upd(OP_ADD, 1'b1, 4'b0111, 1'b1);
        flag_wr    = 1'b1;
        flag_wdata = 4'b1000;
        cond_valid = 1'b1;
        cond       = COND_MI;
        tick();
        check("wr prio flags", flags_q, 4'b1000);
        check("wr prio cin", {3'b0, cin}, 4'd0);
        check("bypass MI", {3'b0, cond_pass}, 4'd1);

        // Forwarded ALU update seen by same-cycle query.
        alu_upd(OP_ADD, 1'b1, 4'b0100, 1'b0);
        cond_valid = 1'b1;
        cond       = COND_EQ;
        tick();
        check("alu bypass EQ", {3'b0, cond_pass}, 4'd1);

        // Hand-computed table, back-to-back with forwarded direct writes.
        foreach (vecs[i]) begin
            idle();
            flag_wr    = 1'b1;
            flag_wdata = vecs[i].wdata;
            cond_valid = 1'b1;
            cond       = vecs[i].cnd;
            tick();
            check($sformatf("vec%0d flags", i), flags_q, vecs[i].wdata);
            check($sformatf("vec%0d valid", i), {3'b0, cond_out_valid}, 4'd1);
            check($sformatf("vec%0d pass", i), {3'b0, cond_pass}, {3'b0, vecs[i].exp});
        end

        // Full sweep, back-to-back.
        last_exp = 1'b0;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                idle();
                flag_wr    = 1'b1;
                flag_wdata = 4'(f);
                cond_valid = 1'b1;
                cond       = 4'(c);
                last_exp   = ref_pass(4'(c), 4'(f));
                tick();
                check($sformatf("sweep c%0h f%b", c, 4'(f)), {3'b0, cond_pass},
                      {3'b0, last_exp});
                check($sformatf("sweep valid c%0h", c), {3'b0, cond_out_valid}, 4'd1);
            end
        end

        // cond_valid=0: valid drops, pass holds even though the new cond would differ.
        idle();
        cond = last_exp ? COND_NV : COND_AL;
        tick();
        check("idle valid", {3'b0, cond_out_valid}, 4'd0);
        check("idle hold", {3'b0, cond_pass}, {3'b0, last_exp});

        // Reset mid-query discards it.
        idle();
        flag_wr    = 1'b1;
        flag_wdata = 4'b1111;
        tick();
        check("pre-rst flags", flags_q, 4'b1111);
        idle();
        cond_valid = 1'b1;
        cond       = COND_AL;
        rst_n      = 1'b0;
        tick();
        check("mid rst flags", flags_q, 4'b0000);
        check("mid rst valid", {3'b0, cond_out_valid}, 4'd0);
        check("mid rst cin", {3'b0, cin}, 4'd0);
        check("mid rst pass", {3'b0, cond_pass}, 4'd0);
        rst_n      = 1'b1;
        cond_valid = 1'b0;
        tick();
        check("post rst valid", {3'b0, cond_out_valid}, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
